// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding imem request at a time, a single-entry
// IF/ID buffer with valid/ready toward decode, flush redirect and halt on misaligned PC.
module if_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    output logic        fetch_ready,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_misaligned
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] req_pc;
    logic        drop;

    logic buf_free;
    logic pc_aligned;
    logic load_mis;

    assign buf_free   = !id_valid || id_ready;
    assign pc_aligned = (pc[1:0] == 2'b00);

    // Request/consume strobes are forced low while reset is held, even though the
    // state register already sits in S_REQ.
    always_comb begin
        imem_req    = 1'b0;
        fetch_ready = 1'b0;
        load_mis    = 1'b0;
        imem_addr   = (state == S_REQ) ? pc : req_pc;
        if (rst_n) begin
            if (state == S_REQ && buf_free && !flush) begin
                imem_req = pc_aligned;
                load_mis = !pc_aligned;
            end
            if (state == S_WAIT && imem_rvalid && !flush && !drop)
                fetch_ready = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_REQ;
            req_pc        <= 32'h0;
            drop          <= 1'b0;
            id_valid      <= 1'b0;
            id_misaligned <= 1'b0;
            id_instr      <= NOP_INSTR;
            id_pc         <= 32'h0;
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_req) begin
                        req_pc <= pc;
                        state  <= S_WAIT;
                    end else if (load_mis) begin
                        state <= S_HALT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        drop  <= 1'b0;
                        state <= S_REQ;
                    end else if (flush) begin
                        drop <= 1'b1;
                    end
                end
                S_HALT: begin
                    if (flush)
                        state <= S_REQ;
                end
                default: state <= S_REQ;
            endcase

            // Flush wins over both a load and a drain of the buffer.
            if (flush) begin
                id_valid      <= 1'b0;
                id_misaligned <= 1'b0;
            end else if (fetch_ready) begin
                id_valid      <= 1'b1;
                id_misaligned <= 1'b0;
                id_instr      <= imem_rdata;
                id_pc         <= req_pc;
            end else if (load_mis) begin
                id_valid      <= 1'b1;
                id_misaligned <= 1'b1;
                id_instr      <= NOP_INSTR;
                id_pc         <= pc;
            end else if (id_valid && id_ready) begin
                id_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage: the bench plays both the upstream PC logic and
// the instruction memory, driving each cycle by hand.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        fetch_ready;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_misaligned;

    int checks   = 0;
    int failures = 0;

    if_stage #(.NOP_INSTR(32'h0000_0013)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc            (pc),
        .fetch_ready   (fetch_ready),
        .flush         (flush),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .id_misaligned (id_misaligned)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        pc          = 32'h0;
        flush       = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        id_ready    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        pc          = 32'h40;
        flush       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hFFFF_FFFF;
        id_ready    = 1'b1;
        tick();
        tick();
        checks++;
        if (imem_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_imem_req got=%b exp=0", imem_req);
        end
        checks++;
        if (fetch_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_fetch_ready got=%b exp=0", fetch_ready);
        end
        checks++;
        if (id_valid !== 1'b0 || id_misaligned !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_valid got=%b/%b exp=0/0", id_valid, id_misaligned);
        end
        checks++;
        if (id_instr !== 32'h0000_0013 || id_pc !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_buffer got=%h/%h exp=00000013/00000000", id_instr, id_pc);
        end
        rst_n       = 1'b1;
        imem_rvalid = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            failures++;
            $display("[TB] FAIL reset_first_req got=%b/%h exp=1/00000040", imem_req, imem_addr);
        end
        tick();
    endtask

    task automatic test_streaming();
        int pulses = 0;
        do_reset();
        id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc          = 32'(4 * i);
            imem_rvalid = 1'b0;
            #1;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin
                failures++;
                $display("[TB] FAIL stream_req%0d got=%b/%h exp=1/%h", i, imem_req, imem_addr, 32'(4 * i));
            end
            if (fetch_ready === 1'b1) pulses++;
            tick();
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hA + 32'(i);
            #1;
            if (fetch_ready === 1'b1) pulses++;
            tick();
            checks++;
            if (id_valid !== 1'b1 || id_instr !== 32'hA + 32'(i) || id_pc !== 32'(4 * i)) begin
                failures++;
                $display("[TB] FAIL stream_out%0d got=%b/%h/%h exp=1/%h/%h",
                         i, id_valid, id_instr, id_pc, 32'hA + 32'(i), 32'(4 * i));
            end
        end
        imem_rvalid = 1'b0;
        checks++;
        if (pulses != 3) begin
            failures++;
            $display("[TB] FAIL stream_fetch_ready_pulses got=%0d exp=3", pulses);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        id_ready = 1'b0;
        pc       = 32'h20;
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h55;
        tick();
        imem_rvalid = 1'b0;
        pc          = 32'h24;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (imem_req !== 1'b0) begin
                failures++;
                $display("[TB] FAIL bp_no_req%0d got=%b exp=0", i, imem_req);
            end
            tick();
            checks++;
            if (id_valid !== 1'b1 || id_instr !== 32'h55 || id_pc !== 32'h20) begin
                failures++;
                $display("[TB] FAIL bp_hold%0d got=%b/%h/%h exp=1/00000055/00000020",
                         i, id_valid, id_instr, id_pc);
            end
        end
        id_ready = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h24) begin
            failures++;
            $display("[TB] FAIL bp_release_req got=%b/%h exp=1/00000024", imem_req, imem_addr);
        end
        tick();
        checks++;
        if (id_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_drain got=%b exp=0", id_valid);
        end
    endtask

    task automatic test_flush_wait();
        do_reset();
        id_ready = 1'b1;
        pc       = 32'h10;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            failures++;
            $display("[TB] FAIL fw_req got=%b/%h exp=1/00000010", imem_req, imem_addr);
        end
        tick();
        tick();
        flush = 1'b1;
        #1;
        checks++;
        if (fetch_ready !== 1'b0 || imem_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fw_flush_cycle got=%b/%b exp=0/0", fetch_ready, imem_req);
        end
        tick();
        flush = 1'b0;
        pc    = 32'h100;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fw_still_waiting got=%b exp=0", imem_req);
        end
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD;
        #1;
        checks++;
        if (fetch_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fw_drop_fetch_ready got=%b exp=0", fetch_ready);
        end
        tick();
        imem_rvalid = 1'b0;
        checks++;
        if (id_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fw_dropped got=%b exp=0", id_valid);
        end
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            failures++;
            $display("[TB] FAIL fw_redirect_req got=%b/%h exp=1/00000100", imem_req, imem_addr);
        end
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h77;
        #1;
        checks++;
        if (fetch_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL fw_resp_fetch_ready got=%b exp=1", fetch_ready);
        end
        tick();
        imem_rvalid = 1'b0;
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== 32'h77) begin
            failures++;
            $display("[TB] FAIL fw_delivered got=%b/%h/%h exp=1/00000100/00000077", id_valid, id_pc, id_instr);
        end
    endtask

    task automatic test_flush_rvalid();
        do_reset();
        id_ready = 1'b1;
        pc       = 32'h30;
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h99;
        flush       = 1'b1;
        #1;
        checks++;
        if (fetch_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fr_fetch_ready got=%b exp=0", fetch_ready);
        end
        tick();
        flush       = 1'b0;
        imem_rvalid = 1'b0;
        pc          = 32'h300;
        #1;
        checks++;
        if (id_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fr_valid got=%b exp=0", id_valid);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            failures++;
            $display("[TB] FAIL fr_redirect_req got=%b/%h exp=1/00000300", imem_req, imem_addr);
        end
        tick();
    endtask

    task automatic test_misaligned();
        do_reset();
        id_ready = 1'b0;
        pc       = 32'h6;
        #1;
        checks++;
        if (imem_req !== 1'b0 || fetch_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mis_no_req got=%b/%b exp=0/0", imem_req, fetch_ready);
        end
        tick();
        checks++;
        if (id_valid !== 1'b1 || id_misaligned !== 1'b1 || id_pc !== 32'h6 || id_instr !== 32'h13) begin
            failures++;
            $display("[TB] FAIL mis_marker got=%b/%b/%h/%h exp=1/1/00000006/00000013",
                     id_valid, id_misaligned, id_pc, id_instr);
        end
        id_ready = 1'b1;
        pc       = 32'h8;
        for (int i = 0; i < 10; i++) begin
            imem_rvalid = i[0];
            imem_rdata  = 32'hBAD0 + 32'(i);
            #1;
            checks++;
            if (imem_req !== 1'b0 || fetch_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL mis_halted%0d got=%b/%b exp=0/0", i, imem_req, fetch_ready);
            end
            tick();
        end
        imem_rvalid = 1'b0;
        checks++;
        if (id_instr !== 32'h13 || id_pc !== 32'h6) begin
            failures++;
            $display("[TB] FAIL mis_ignored_resp got=%h/%h exp=00000013/00000006", id_instr, id_pc);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        pc    = 32'h200;
        #1;
        checks++;
        if (id_valid !== 1'b0 || id_misaligned !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mis_flush_clear got=%b/%b exp=0/0", id_valid, id_misaligned);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            failures++;
            $display("[TB] FAIL mis_resume_req got=%b/%h exp=1/00000200", imem_req, imem_addr);
        end
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h42;
        tick();
        imem_rvalid = 1'b0;
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_instr !== 32'h42 || id_misaligned !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mis_resume_out got=%b/%h/%h/%b exp=1/00000200/00000042/0",
                     id_valid, id_pc, id_instr, id_misaligned);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        pc          = 32'h0;
        flush       = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        id_ready    = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_wait();
        test_flush_rvalid();
        test_misaligned();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
